// File: rtl/ram_share_arb_pkg.sv
// Shared definitions for the RAM demo blocks: FSM encodings, read-tag layout,
// and default RAM geometry.
package ram_share_arb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef struct packed {
    logic vld;
    logic owner;
  } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-length delay line carrying {valid, owner} read tags alongside the RAM
// read latency; async reset drops every tag in flight.
module rd_tag_pipe
  import ram_share_arb_pkg::*;
#(
  parameter int LEN = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o,
  output logic    any_vld_o
);
  rd_tag_t [LEN-1:0] stg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= tag_i;
      for (int i = 1; i < LEN; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  always_comb begin
    any_vld_o = 1'b0;
    for (int i = 0; i < LEN; i++) any_vld_o = any_vld_o | stg_q[i].vld;
  end

  assign tag_o = stg_q[LEN-1];
endmodule

// File: rtl/ram_share_arb.sv
// Round-robin, burst-bounded arbiter sharing one single-port RAM between two
// masters; registered RAM port, read data steered back by owner tag.
module ram_share_arb
  import ram_share_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy
);
  // One bit wider than 4 so that MAX_BURST=16 is actually reachable.
  localparam int                BCNT_W = 5;
  localparam logic [BCNT_W-1:0] BMAX   = BCNT_W'(MAX_BURST);
  localparam logic [BCNT_W-1:0] BONE   = BCNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              g0, g1, gnt_any;
  logic              en_q, we_q, rv0_q, rv1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q, rd0_q, rd1_q;
  logic              win_we;
  rd_tag_t           tag_in, tag_out;
  logic              pipe_busy;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    bcnt_d  = bcnt_q;
    g0      = 1'b0;
    g1      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rr names the last owner, so a tie goes to the other master.
        if (m0_req && (!m1_req || rr_q)) begin
          g0 = 1'b1; state_d = ST_OWN0; bcnt_d = BONE;
        end else if (m1_req) begin
          g1 = 1'b1; state_d = ST_OWN1; bcnt_d = BONE;
        end
      end
      ST_OWN0: begin
        if (m0_req && (!m1_req || bcnt_q < BMAX)) begin
          g0 = 1'b1;
          if (bcnt_q < BMAX) bcnt_d = bcnt_q + BONE;
        end else if (m1_req) begin
          g1 = 1'b1; state_d = ST_OWN1; bcnt_d = BONE; rr_d = 1'b0;
        end else begin
          state_d = ST_IDLE; bcnt_d = '0; rr_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (m1_req && (!m0_req || bcnt_q < BMAX)) begin
          g1 = 1'b1;
          if (bcnt_q < BMAX) bcnt_d = bcnt_q + BONE;
        end else if (m0_req) begin
          g0 = 1'b1; state_d = ST_OWN0; bcnt_d = BONE; rr_d = 1'b1;
        end else begin
          state_d = ST_IDLE; bcnt_d = '0; rr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_any = g0 | g1;
  assign win_we  = g1 ? m1_we : m0_we;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b1;
      bcnt_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      bcnt_q  <= bcnt_d;
      en_q    <= gnt_any;
      we_q    <= gnt_any & win_we;
      if (gnt_any) begin
        addr_q <= g1 ? m1_addr  : m0_addr;
        wd_q   <= g1 ? m1_wdata : m0_wdata;
      end
    end
  end

  assign tag_in.vld   = gnt_any & ~win_we;
  assign tag_in.owner = g1;

  rd_tag_pipe #(.LEN(RD_LAT + 1)) u_tag_pipe (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst),
    .tag_i     (tag_in),
    .tag_o     (tag_out),
    .any_vld_o (pipe_busy)
  );

  // Tag exit lines up with ram_rd_data being valid for that read.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      rv0_q <= tag_out.vld & ~tag_out.owner;
      rv1_q <= tag_out.vld &  tag_out.owner;
      if (tag_out.vld && !tag_out.owner) rd0_q <= ram_rd_data;
      if (tag_out.vld &&  tag_out.owner) rd1_q <= ram_rd_data;
    end
  end

  assign m0_gnt      = g0;
  assign m1_gnt      = g1;
  assign m0_rvalid   = rv0_q;
  assign m1_rvalid   = rv1_q;
  assign m0_rdata    = rd0_q;
  assign m1_rdata    = rd1_q;
  assign ram_en      = en_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wr_data = wd_q;
  assign busy        = en_q | pipe_busy;
endmodule
